// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Round-robin arbiter that merges NM AXI read masters onto one AXI read port.
// Only one read transaction is in flight at a time. The granted master's AR
// channel is passed straight through to the bus. Its R channel handshake is
// routed back to it. R data, resp and last are broadcast to every master.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   m_arvalid/m_arready       per-master AR handshake (NM bits)
//   m_araddr, m_arlen         per-master AR payload, master i in slice i
//   m_rvalid/m_rready         per-master R handshake (NM bits)
//   m_rdata/m_rresp/m_rlast   R payload broadcast to all masters
//   s_ar*                     AR channel towards the bus slave
//   s_r*                      R channel from the bus slave
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int          NM      = 2,
    parameter int          ADDR_W  = 64,
    parameter int          DATA_W  = 64,
    parameter logic [3:0]  ID_BASE = 4'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NM-1:0]        m_arvalid,
    output logic [NM-1:0]        m_arready,
    input  logic [NM*ADDR_W-1:0] m_araddr,
    input  logic [NM*8-1:0]      m_arlen,
    output logic [NM-1:0]        m_rvalid,
    input  logic [NM-1:0]        m_rready,
    output logic [DATA_W-1:0]    m_rdata,
    output logic [1:0]           m_rresp,
    output logic                 m_rlast,
    output logic                 s_arvalid,
    input  logic                 s_arready,
    output logic [ADDR_W-1:0]    s_araddr,
    output logic [7:0]           s_arlen,
    output logic [3:0]           s_arid,
    input  logic                 s_rvalid,
    output logic                 s_rready,
    input  logic [DATA_W-1:0]    s_rdata,
    input  logic [1:0]           s_rresp,
    input  logic                 s_rlast
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;

    // Pick the first requester after 'last', wrapping modulo NM. The scan
    // covers last+1 ... last+NM, so 'last' itself has the lowest priority.
    function automatic logic [GW-1:0] rr_pick(input logic [NM-1:0] req,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NM; k++) begin
            idx = (int'(last) + k) % NM;
            if (!found && req[GW'(idx)]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Transaction FSM: arbitrate in IDLE, wait for AR accept, then wait for the last R beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NM - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|m_arvalid) begin
                        grant <= rr_pick(m_arvalid, last_grant);
                        state <= ADDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADDR: begin
                    if (s_arvalid && s_arready) begin
                        state <= DATA;
                    end else begin
                        state <= ADDR;
                    end
                end
                DATA: begin
                    // Only the rlast beat ends the burst. Earlier beats keep the grant.
                    if (s_rvalid && s_rready && s_rlast) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end else begin
                        state <= DATA;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The AR payload follows the registered grant. The address is not
    // latched, because masters hold it stable until the bus accepts it.
    assign s_araddr = m_araddr[int'(grant)*ADDR_W +: ADDR_W];
    assign s_arlen  = m_arlen[int'(grant)*8 +: 8];
    assign s_arid   = ID_BASE + 4'(grant);

    // The R payload is broadcast. Only rvalid tells a master the beat is its own.
    assign m_rdata  = s_rdata;
    assign m_rresp  = s_rresp;
    assign m_rlast  = s_rlast;

    // Handshake steering: only the granted master sees the bus, and only in the matching phase.
    always_comb begin
        s_arvalid = 1'b0;
        m_arready = '0;
        s_rready  = 1'b0;
        m_rvalid  = '0;
        case (state)
            ADDR: begin
                s_arvalid        = m_arvalid[grant];
                m_arready[grant] = s_arready;
            end
            DATA: begin
                s_rready        = m_rready[grant];
                m_rvalid[grant] = s_rvalid;
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed, table-driven bench for axi_rd_arbiter with NM=2. Each table row
// gives the inputs for one clock cycle and the handshake/ID/address outputs
// expected in that cycle. The state at the start of a row is the result of the
// edges of the earlier rows. After the table, a hand-written sequence checks
// R payload forwarding and the one-IDLE-cycle turnaround.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam logic [63:0] A0 = 64'h0000_0000_0000_1000;
    localparam logic [63:0] A1 = 64'h0000_0000_8000_0003;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    m_arvalid;
    logic [1:0]    m_arready;
    logic [127:0]  m_araddr;
    logic [15:0]   m_arlen;
    logic [1:0]    m_rvalid;
    logic [1:0]    m_rready;
    logic [63:0]   m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          s_arvalid;
    logic          s_arready;
    logic [63:0]   s_araddr;
    logic [7:0]    s_arlen;
    logic [3:0]    s_arid;
    logic          s_rvalid;
    logic          s_rready;
    logic [63:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.NM(2), .ADDR_W(64), .DATA_W(64), .ID_BASE(4'h0)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  arv;
        logic        sar;
        logic        srv;
        logic        srl;
        logic [1:0]  mrr;
        logic        e_sav;
        logic [1:0]  e_mar;
        logic [1:0]  e_mrv;
        logic        e_srr;
        logic [3:0]  e_id;
        logic [63:0] e_addr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [1:0] arv, logic sar, logic srv, logic srl,
                                logic [1:0] mrr, logic e_sav, logic [1:0] e_mar,
                                logic [1:0] e_mrv, logic e_srr, logic [3:0] e_id,
                                logic [63:0] e_addr);
        vec_t v;
        v.rst = r; v.arv = arv; v.sar = sar; v.srv = srv; v.srl = srl; v.mrr = mrr;
        v.e_sav = e_sav; v.e_mar = e_mar; v.e_mrv = e_mrv; v.e_srr = e_srr;
        v.e_id = e_id; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;

        m_araddr  = {A1, A0};
        m_arlen   = {8'd1, 8'd0};
        s_rdata   = 64'h0123_4567_89AB_CDEF;
        s_rresp   = 2'b00;
        rst       = 1'b1;
        m_arvalid = 2'b00;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        m_rready  = 2'b00;
        tick();
        tick();

        //                rst  arv    sar   srv   srl   mrr    sav   mar    mrv    srr   id     addr
        vt.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, A0)); // 0 reset state
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, A0)); // 1 IDLE, both request
        vt.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 2'b00, 1'b0, 4'd0, A0)); // 2 ADDR m0 accepted
        vt.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 4'd0, A0)); // 3 DATA m0 last beat
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, A0)); // 4 IDLE -> grant m1
        for (int i = 0; i < 5; i++) begin
            vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1, A1)); // 5-9 arready stall
        end
        vt.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b0, 4'd1, A1)); // 10 m1 accepted
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 4'd1, A1)); // 11 beat 1 of 2
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 2'b10, 1'b0, 4'd1, A1)); // 12 m1 rready low
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 4'd1, A1)); // 13 beat 2 accepted
        vt.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, A1)); // 14 IDLE, only m1
        vt.push_back(mk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b0, 4'd1, A1)); // 15 m1 accepted
        vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 4'd1, A1)); // 16 rst in beat 1
        vt.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, A0)); // 17 back to IDLE
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, A0)); // 18 both -> m0
        vt.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b0, 4'd0, A0)); // 19 m0 accepted
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 4'd0, A0)); // 20 m0 last beat
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, A0)); // 21 IDLE -> m1
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1, A1)); // 22 ADDR m1

        for (int r = 0; r < vt.size(); r++) begin
            rst       = vt[r].rst;
            m_arvalid = vt[r].arv;
            s_arready = vt[r].sar;
            s_rvalid  = vt[r].srv;
            s_rlast   = vt[r].srl;
            m_rready  = vt[r].mrr;
            #1;
            chk("s_arvalid", r, 64'(s_arvalid), 64'(vt[r].e_sav));
            chk("m_arready", r, 64'(m_arready), 64'(vt[r].e_mar));
            chk("m_rvalid",  r, 64'(m_rvalid),  64'(vt[r].e_mrv));
            chk("s_rready",  r, 64'(s_rready),  64'(vt[r].e_srr));
            chk("s_arid",    r, 64'(s_arid),    64'(vt[r].e_id));
            chk("s_araddr",  r, s_araddr,       vt[r].e_addr);
            tick();
        end

        // m1 (still in ADDR) is accepted now. Its arlen of 1 also shows on the bus.
        m_arvalid = 2'b10;
        s_arready = 1'b1;
        #1;
        chk("s_arlen", 100, 64'(s_arlen), 64'd1);
        tick();

        // Final beat carries a distinctive payload while m0 raises its request.
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b1;
        s_rdata   = 64'hDEAD_BEEF_0123_4567;
        s_rresp   = 2'b10;
        m_rready  = 2'b11;
        m_arvalid = 2'b01;
        #1;
        chk("m_rdata",  101, m_rdata,         64'hDEAD_BEEF_0123_4567);
        chk("m_rresp",  101, 64'(m_rresp),    64'd2);
        chk("m_rlast",  101, 64'(m_rlast),    64'd1);
        chk("m_rvalid", 101, 64'(m_rvalid),   64'(2'b10));
        tick();

        // Exactly one IDLE cycle should separate the last beat from the next AR.
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        cyc = 0;
        #1;
        while (!s_arvalid && cyc < 5) begin
            tick();
            cyc++;
        end
        chk("turnaround_cycles", 102, 64'(cyc), 64'd1);
        chk("s_arid_m0",         102, 64'(s_arid), 64'd0);
        chk("s_araddr_m0",       102, s_araddr, A0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
